// File: rtl/edu_pkg.sv
// rtl/edu_pkg.sv - shared constants, types and helpers for the edu register block
package edu_pkg;

  // BAR0 byte offsets
  localparam int unsigned OFF_ID         = 32'h00;
  localparam int unsigned OFF_LIVENESS   = 32'h04;
  localparam int unsigned OFF_FACT       = 32'h08;
  localparam int unsigned OFF_STATUS     = 32'h20;
  localparam int unsigned OFF_IRQ_STATUS = 32'h24;
  localparam int unsigned OFF_IRQ_RAISE  = 32'h60;
  localparam int unsigned OFF_IRQ_ACK    = 32'h64;

  // STATUS register bit positions
  localparam int unsigned ST_BUSY_BIT   = 0;
  localparam int unsigned ST_IRQ_EN_BIT = 7;

  // IRQ_STATUS bit set when the factorial engine finishes
  localparam int unsigned IRQ_FACT_BIT = 0;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h010000ed;

  typedef enum logic {
    FACT_IDLE = 1'b0,
    FACT_RUN  = 1'b1
  } fact_state_e;

  // Expand the four byte enables into a 32-bit write mask
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/edu_fact.sv
// rtl/edu_fact.sv - iterative 32-bit factorial engine, one multiply per cycle
module edu_fact
  import edu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  fact_state_e state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  // State and datapath registers; reset aborts any computation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FACT_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next state: the terminating RUN cycle doubles as the DONE cycle, so busy
  // stays high for exactly n-1 multiplies plus one
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done     = 1'b0;
    case (state_q)
      FACT_IDLE: begin
        if (start) begin
          acc_d   = 32'd1;
          cnt_d   = operand;
          state_d = FACT_RUN;
        end
      end
      FACT_RUN: begin
        if (cnt_q <= 32'd1 || acc_q == 32'd0) begin
          result_d = acc_q;
          done     = 1'b1;
          state_d  = FACT_IDLE;
        end else begin
          acc_d = acc_q * cnt_q;
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = FACT_IDLE;
    endcase
  end

  assign busy   = (state_q == FACT_RUN);
  assign result = result_q;

endmodule

// File: rtl/edu_mmio.sv
// rtl/edu_mmio.sv - BAR0 register decode, factorial control and INTx generation
module edu_mmio
  import edu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT,
  parameter int unsigned INT_PIN  = 0,
  parameter int unsigned IRQ_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] lb_addr,
  input  logic [31:0]       lb_wdata,
  input  logic [3:0]        lb_be,
  input  logic              lb_wr,
  input  logic              lb_rd,
  output logic [31:0]       lb_rdata,
  output logic              lb_ack,
  input  logic              intx_disable,
  output logic              int_status,
  output logic              inta,
  output logic              intb,
  output logic              intc,
  output logic              intd
);

  localparam logic [1:0] PIN_SEL = 2'(INT_PIN);

  logic [ADDR_W-1:0] byte_addr;
  logic sel_id, sel_liv, sel_fact, sel_status, sel_irq, sel_raise, sel_ack;
  logic [31:0] wr_mask, wr_bits;

  logic [31:0]      liveness_q, liveness_d;
  logic [31:0]      operand_q, operand_d;
  logic             irq_en_q, irq_en_d;
  logic [IRQ_W-1:0] irq_q, irq_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             int_status_q, int_status_d;
  logic [3:0]       intx_q, intx_d;
  logic [31:0]      rd_data;

  logic        fact_start, fact_busy, fact_done;
  logic [31:0] fact_result;

  assign byte_addr  = {lb_addr, 2'b00};
  assign sel_id     = (byte_addr == ADDR_W'(OFF_ID));
  assign sel_liv    = (byte_addr == ADDR_W'(OFF_LIVENESS));
  assign sel_fact   = (byte_addr == ADDR_W'(OFF_FACT));
  assign sel_status = (byte_addr == ADDR_W'(OFF_STATUS));
  assign sel_irq    = (byte_addr == ADDR_W'(OFF_IRQ_STATUS));
  assign sel_raise  = (byte_addr == ADDR_W'(OFF_IRQ_RAISE));
  assign sel_ack    = (byte_addr == ADDR_W'(OFF_IRQ_ACK));

  assign wr_mask    = be_mask(lb_be);
  assign wr_bits    = lb_wdata & wr_mask;
  assign fact_start = lb_wr && sel_fact && !fact_busy;

  edu_fact u_fact (
    .clk     (clk),
    .rst     (rst),
    .start   (fact_start),
    .operand (operand_d),
    .busy    (fact_busy),
    .done    (fact_done),
    .result  (fact_result)
  );

  // All software-visible and bus-response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      liveness_q   <= '0;
      operand_q    <= '0;
      irq_en_q     <= 1'b0;
      irq_q        <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      int_status_q <= 1'b0;
      intx_q       <= 4'hF;
    end else begin
      liveness_q   <= liveness_d;
      operand_q    <= operand_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      int_status_q <= int_status_d;
      intx_q       <= intx_d;
    end
  end

  // Register writes; the operand is merged first so a start sees the new bytes
  always_comb begin
    liveness_d = liveness_q;
    operand_d  = operand_q;
    irq_en_d   = irq_en_q;
    irq_d      = irq_q;
    if (lb_wr && sel_liv)
      liveness_d = (liveness_q & ~wr_mask) | wr_bits;
    if (lb_wr && sel_fact && !fact_busy)
      operand_d = (operand_q & ~wr_mask) | wr_bits;
    if (lb_wr && sel_status && lb_be[0])
      irq_en_d = lb_wdata[ST_IRQ_EN_BIT];
    if (lb_wr && sel_raise)
      irq_d = irq_q | wr_bits[IRQ_W-1:0];
    if (lb_wr && sel_ack)
      irq_d = irq_q & ~wr_bits[IRQ_W-1:0];
    // Applied last so a completion beats a same-cycle acknowledge
    if (fact_done && irq_en_q)
      irq_d[IRQ_FACT_BIT] = 1'b1;
  end

  // Read mux; unmapped and write-only offsets return zero
  always_comb begin
    rd_data = '0;
    if (sel_id)
      rd_data = ID_VALUE;
    else if (sel_liv)
      rd_data = ~liveness_q;
    else if (sel_fact)
      rd_data = fact_result;
    else if (sel_status) begin
      rd_data[ST_BUSY_BIT]   = fact_busy;
      rd_data[ST_IRQ_EN_BIT] = irq_en_q;
    end else if (sel_irq)
      rd_data[IRQ_W-1:0] = irq_q;
  end

  // Bus response one cycle after the strobe; data is forced to zero off-ack
  always_comb begin
    ack_d   = lb_rd | lb_wr;
    rdata_d = lb_rd ? rd_data : 32'd0;
  end

  // Interrupt outputs follow IRQ_STATUS and intx_disable with one cycle of delay
  always_comb begin
    int_status_d = |irq_q;
    intx_d       = 4'hF;
    if ((|irq_q) && !intx_disable)
      intx_d[PIN_SEL] = 1'b0;
  end

  assign lb_ack     = ack_q;
  assign lb_rdata   = rdata_q;
  assign int_status = int_status_q;
  assign inta       = intx_q[0];
  assign intb       = intx_q[1];
  assign intc       = intx_q[2];
  assign intd       = intx_q[3];

endmodule
